r4_sdf_butterfly_stage: RTL
===========================

R4_SDF_BUTTERFLY_STAGE -- requirements
Module: r4_sdf_butterfly_stage

Interface
REQ-001 Parameter DEPTH, default 16, meaning quarter-block length D; power of two, >= 2; one block is 4*D samples.
REQ-002 Parameter WIDTH, default 32, meaning width of each signed two's-complement real/imag sample.
REQ-003 clock  input  1  rising-edge clock; reset reset, synchronous, active-high; clock clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  serial input sample valid this cycle.
REQ-006 in_real, in_imag  input  WIDTH each  serial input sample, signed.
REQ-007 out_valid  output  1  one-cycle pulse; drives downstream delay-buffer write enable.
REQ-008 out_real_0..out_real_3, out_imag_0..out_imag_3  output  WIDTH each  butterfly results y0..y3, signed.
REQ-009 out_first  output  1  high with out_valid on the first result of a block.
REQ-010 out_last  output  1  high with out_valid on the last (D-th) result of a block.

Function
REQ-011 The block SHALL keep a sample counter cnt, range 0..4*D-1, advancing by one only on cycles with in_valid=1, wrapping from 4*D-1 to 0.
REQ-012 The phase SHALL be cnt[top two bits]: FILL0, FILL1, FILL2 (store-only), COMPUTE (4th quarter).
REQ-013 The block SHALL hold a 3*D-entry shift line (real and imag) that shifts one place and loads the input at entry 0 on every in_valid=1 cycle, in all phases.
REQ-014 With in_valid=0, counter, shift line and all outputs except out_valid SHALL hold; out_valid, out_first, out_last SHALL be 0.
REQ-015 On an in_valid=1 cycle in COMPUTE, operands SHALL be x0=line[3D-1], x1=line[2D-1], x2=line[D-1], x3=current input (samples n, n+D, n+2D, n+3D of the block).
REQ-016 Butterfly: y0=x0+x1+x2+x3; y2=x0-x1+x2-x3; y1 real=r0+i1-r2-i3, imag=i0-r1-i2+r3; y3 real=r0-i1-r2+i3, imag=i0+r1-i2-r3.
REQ-017 Sums SHALL be computed at WIDTH+2 bits without overflow, then arithmetic-shifted right by 2 (truncation toward minus infinity) to WIDTH bits.
REQ-018 Results SHALL be registered: out_* updated and out_valid=1 exactly one clock after the COMPUTE input cycle (latency 1).
REQ-019 out_first SHALL be 1 when the producing input had cnt=3*D; out_last SHALL be 1 when it had cnt=4*D-1.
REQ-020 out_*_k SHALL map to y_k (out_real_0=y0 ... out_real_3=y3).
REQ-021 No in-phase ready exists; the block SHALL accept one sample per cycle indefinitely, back-to-back blocks with no gap.
REQ-022 Block wrap (cnt 4*D-1 -> 0) simultaneous with in_valid=1 SHALL emit the last result and start FILL0 of the next block in the same cycle with no lost sample.

Reset
REQ-023 While reset=1, cnt, shift line, all out_real_*/out_imag_* SHALL be cleared to 0 and out_valid, out_first, out_last SHALL be 0 on the next edge.
REQ-024 Reset SHALL take priority over in_valid; reset mid-block SHALL discard the partial block, and the first in_valid after reset SHALL be sample 0 of a new block.

Verification (DEPTH=4, WIDTH=16)
REQ-025 Impulse: block with sample0 real=4, rest 0, in_valid continuous -> first result: all out_real_k=1, out_imag_k=0, out_first=1; remaining three results all 0; out_last on 4th.
REQ-026 DC: 16 samples real=8 -> four results each y0 real=8, y1..y3=0, imag all 0; out_valid exactly 4 pulses at cycles 13..16 after first input.
REQ-027 Extremes: all samples real=32767 -> y0 real=32767; all -32768 -> y0 real=-32768; no wrap-around.
REQ-028 Stall: same DC block with in_valid toggling 1,0 -> identical results, out_valid only one cycle after each COMPUTE-phase valid.
REQ-029 Back-to-back: two blocks (impulse then DC) without gap -> results as REQ-025 then REQ-026, out_first/out_last correct for each.
REQ-030 Reset mid-block: reset after 7 samples, then full impulse block -> outputs match REQ-025; no out_valid during or after reset before cnt reaches 12.

Source files
------------

// File: rtl/r4_sdf_butterfly_stage.sv
// r4_sdf_butterfly_stage: radix-4 single-delay-feedback butterfly over 4*DEPTH-sample blocks.
// The first three quarters of a block are held in a 3*DEPTH delay line; the fourth quarter triggers the butterflies.
module r4_sdf_butterfly_stage #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    out_valid,
    output logic                    out_first,
    output logic                    out_last,
    output logic signed [WIDTH-1:0] out_real_0,
    output logic signed [WIDTH-1:0] out_real_1,
    output logic signed [WIDTH-1:0] out_real_2,
    output logic signed [WIDTH-1:0] out_real_3,
    output logic signed [WIDTH-1:0] out_imag_0,
    output logic signed [WIDTH-1:0] out_imag_1,
    output logic signed [WIDTH-1:0] out_imag_2,
    output logic signed [WIDTH-1:0] out_imag_3
);
    localparam int CW = $clog2(4 * DEPTH);
    localparam int L  = 3 * DEPTH;
    localparam int SW = WIDTH + 2;

    logic [CW-1:0] cnt;
    logic signed [WIDTH-1:0] line_re [L];
    logic signed [WIDTH-1:0] line_im [L];
    logic signed [SW-1:0] r0, r1, r2, r3, i0, i1, i2, i3;
    logic signed [SW-1:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;
    logic compute;

    assign compute = in_valid && (cnt[CW-1 -: 2] == 2'b11);

    // Two guard bits make the four-term sums overflow-free before the /4 scaling.
    always_comb begin
        r0 = SW'(line_re[L-1]);
        i0 = SW'(line_im[L-1]);
        r1 = SW'(line_re[2*DEPTH-1]);
        i1 = SW'(line_im[2*DEPTH-1]);
        r2 = SW'(line_re[DEPTH-1]);
        i2 = SW'(line_im[DEPTH-1]);
        r3 = SW'(in_real);
        i3 = SW'(in_imag);
        y0r = r0 + r1 + r2 + r3;
        y0i = i0 + i1 + i2 + i3;
        y1r = r0 + i1 - r2 - i3;
        y1i = i0 - r1 - i2 + r3;
        y2r = r0 - r1 + r2 - r3;
        y2i = i0 - i1 + i2 - i3;
        y3r = r0 - i1 - r2 + i3;
        y3i = i0 + r1 - i2 - r3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            line_re    <= '{default: '0};
            line_im    <= '{default: '0};
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_real_0 <= '0;
            out_real_1 <= '0;
            out_real_2 <= '0;
            out_real_3 <= '0;
            out_imag_0 <= '0;
            out_imag_1 <= '0;
            out_imag_2 <= '0;
            out_imag_3 <= '0;
        end else begin
            out_valid <= compute;
            out_first <= compute && (cnt == CW'(L));
            out_last  <= compute && (cnt == '1);
            if (in_valid) begin
                cnt        <= cnt + CW'(1);
                line_re[0] <= in_real;
                line_im[0] <= in_imag;
                for (int i = 1; i < L; i++) begin
                    line_re[i] <= line_re[i-1];
                    line_im[i] <= line_im[i-1];
                end
            end
            if (compute) begin
                out_real_0 <= WIDTH'(y0r >>> 2);
                out_imag_0 <= WIDTH'(y0i >>> 2);
                out_real_1 <= WIDTH'(y1r >>> 2);
                out_imag_1 <= WIDTH'(y1i >>> 2);
                out_real_2 <= WIDTH'(y2r >>> 2);
                out_imag_2 <= WIDTH'(y2i >>> 2);
                out_real_3 <= WIDTH'(y3r >>> 2);
                out_imag_3 <= WIDTH'(y3i >>> 2);
            end
        end
    end
endmodule
